fib_arbiter: RTL and testbench
==============================

FIB_ARBITER -- requirements
Module: fib_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one fib engine; legal range 2..16.
REQ-002 Parameter INPUT_WIDTH, default 8: width of the index n.
REQ-003 Parameter OUTPUT_WIDTH, default 32: width of the result F(n).
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit, used only under FIB_ARB_TIMEOUT_EN.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 req_vld  in  NUM_REQ  per-requester request valid.
REQ-009 req_n  in  NUM_REQ*INPUT_WIDTH  packed indices; requester i owns slice [i*INPUT_WIDTH +: INPUT_WIDTH].
REQ-010 req_rdy  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-011 rsp_vld  out  NUM_REQ  per-requester response valid; at most one bit high.
REQ-012 rsp_data  out  OUTPUT_WIDTH  shared response data.
REQ-013 rsp_rdy  in  NUM_REQ  per-requester response accept.
REQ-014 eng_fib_in  out  INPUT_WIDTH  index to the engine.
REQ-015 eng_vld  out  1  request valid to the engine.
REQ-016 eng_rdy  in  1  engine ready to accept.
REQ-017 eng_res  in  OUTPUT_WIDTH  engine result.
REQ-018 eng_res_vld  in  1  engine result valid.
REQ-019 eng_res_rdy  out  1  arbiter ready for the engine result.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, and exactly one request SHALL be outstanding at a time.
REQ-021 IDLE: the grant SHALL go to the first requester with req_vld=1, searching cyclically from rr_ptr; only that requester's req_rdy SHALL be high, combinationally in the same cycle.
REQ-022 On a handshake in IDLE, the arbiter SHALL latch the grant id and req_n slice, then move to ISSUE next cycle.
REQ-023 ISSUE: eng_vld=1 and eng_fib_in=latched n; when eng_rdy=1, the arbiter SHALL move to WAIT.
REQ-024 WAIT: eng_res_rdy=1; when eng_res_vld=1, the arbiter SHALL register eng_res into rsp_data and move to RESP.
REQ-025 RESP: rsp_vld[grant]=1; when rsp_rdy[grant]=1, the arbiter SHALL return to IDLE and set rr_ptr to (grant+1) mod NUM_REQ.
REQ-026 rr_ptr SHALL wrap from NUM_REQ-1 to 0; a lone requester SHALL be re-granted on consecutive transactions.
REQ-027 Minimum latency: handshake in cycle 0, eng_vld in cycle 1, rsp_vld in the cycle after eng_res is captured.
REQ-028 req_vld and rsp_rdy of non-granted requesters SHALL be ignored outside their own grant.
REQ-029 rsp_data SHALL hold its last value outside RESP; eng_fib_in SHALL hold the latched n.
REQ-030 Outside ISSUE, eng_vld SHALL be 0; outside WAIT, eng_res_rdy SHALL be 0, except as stated in REQ-036.

Reset
REQ-031 While rst=1: state=IDLE, rr_ptr=0, rsp_data=0, latched n=0, grant id=0.
REQ-032 While rst=1: req_rdy=0, rsp_vld=0, eng_vld=0, eng_res_rdy=0.
REQ-033 Reset mid-transaction SHALL discard the pending request, and no response SHALL be issued for it; the integrator SHALL reset the engine from the same rst.

Configuration
REQ-034 Macro FIB_ARB_TIMEOUT_EN defined: the arbiter SHALL add output rsp_err (1 bit, reset 0) and a counter that runs in ISSUE and WAIT.
REQ-035 With the macro defined, if the counter reaches TIMEOUT_CYCLES-1 without completion, the arbiter SHALL move to RESP with rsp_data=0 and rsp_err=1; rsp_err=0 on normal completion.
REQ-036 With the macro defined, eng_res_rdy SHALL also be 1 in IDLE, and late engine results SHALL be accepted and discarded.
REQ-037 Macro undefined: no counter, no rsp_err port, and WAIT SHALL block indefinitely.

Verification
REQ-038 Single requester 0 sends n=10, engine stalls eng_rdy 3 cycles -> eng_vld held with eng_fib_in=10 until eng_rdy=1; rsp_vld[0] with rsp_data=55.
REQ-039 All four req_vld high continuously, n=5,6,7,8 -> grants in order 0,1,2,3,0; results 5,8,13,21.
REQ-040 rr_ptr=3 and requesters 1 and 3 valid -> requester 3 granted first, then 1, proving wrap.
REQ-041 rsp_rdy[grant] held low 5 cycles in RESP -> rsp_vld and rsp_data stable; no new req_rdy until the response handshake.
REQ-042 rst pulsed during WAIT -> all outputs 0 next edge and no rsp_vld for the aborted request; new request n=1 returns 1.
REQ-043 FIB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never responds -> rsp_err=1 and rsp_data=0; late eng_res_vld is consumed in IDLE.

Source files
------------

// File: rtl/fib_arbiter.sv
// Round-robin arbiter that shares one Fibonacci engine among NUM_REQ requesters.
// Optional watchdog with rsp_err output is enabled by defining FIB_ARB_TIMEOUT_EN.
module fib_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 8,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_REQ-1:0]             rsp_vld,
  output logic [OUTPUT_WIDTH-1:0]        rsp_data,
  input  logic [NUM_REQ-1:0]             rsp_rdy,
  output logic [INPUT_WIDTH-1:0]         eng_fib_in,
  output logic                           eng_vld,
  input  logic                           eng_rdy,
  input  logic [OUTPUT_WIDTH-1:0]        eng_res,
  input  logic                           eng_res_vld,
  output logic                           eng_res_rdy
`ifdef FIB_ARB_TIMEOUT_EN
  ,
  output logic                           rsp_err
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("fib_arbiter: illegal parameter combination");
  end

  state_t                  state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [INPUT_WIDTH-1:0]  n_q, n_d;
  logic [OUTPUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    sel_found;
  logic [IDW-1:0]          sel_id;

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            expired;

  assign expired = (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;
`endif

  // Descending scan so the requester closest to rr_ptr (smallest offset) wins.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_vld[idx]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    n_d         = n_q;
    rsp_data_d  = rsp_data_q;
    req_rdy     = '0;
    rsp_vld     = '0;
    eng_vld     = 1'b0;
    eng_res_rdy = 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef FIB_ARB_TIMEOUT_EN
        // Late results from an abandoned request are drained here and dropped.
        eng_res_rdy = !rst;
        cnt_d       = '0;
`endif
        if (sel_found && !rst) begin
          req_rdy[sel_id] = 1'b1;
          grant_d         = sel_id;
          n_d             = req_n[sel_id*INPUT_WIDTH +: INPUT_WIDTH];
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        eng_vld = 1'b1;
`ifdef FIB_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (expired) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end else
`endif
        if (eng_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        eng_res_rdy = 1'b1;
`ifdef FIB_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (eng_res_vld) begin
          rsp_data_d = eng_res;
          state_d    = RESP;
`ifdef FIB_ARB_TIMEOUT_EN
          err_d      = 1'b0;
        end else if (expired) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
`endif
        end
      end
      RESP: begin
        rsp_vld[grant_q] = 1'b1;
        if (rsp_rdy[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      n_q        <= '0;
      rsp_data_q <= '0;
`ifdef FIB_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      n_q        <= n_d;
      rsp_data_q <= rsp_data_d;
`ifdef FIB_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign rsp_data   = rsp_data_q;
  assign eng_fib_in = n_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// Directed bench for fib_arbiter: the bench plays the engine and returns hand-computed F(n).
// Timeout checks run only when FIB_ARB_TIMEOUT_EN is defined.
module tb_fib_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_vld;
  logic [31:0] req_n;
  logic [3:0]  req_rdy;
  logic [3:0]  rsp_vld;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_rdy;
  logic [7:0]  eng_fib_in;
  logic        eng_vld;
  logic        eng_rdy;
  logic [31:0] eng_res;
  logic        eng_res_vld;
  logic        eng_res_rdy;
`ifdef FIB_ARB_TIMEOUT_EN
  logic        rsp_err;
`endif

  int errors = 0;
  int checks = 0;

  fib_arbiter #(
    .NUM_REQ(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_n(req_n), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
    .eng_fib_in(eng_fib_in), .eng_vld(eng_vld), .eng_rdy(eng_rdy),
    .eng_res(eng_res), .eng_res_vld(eng_res_vld), .eng_res_rdy(eng_res_rdy)
`ifdef FIB_ARB_TIMEOUT_EN
    , .rsp_err(rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int id);
    logic [3:0] one;
    one = 4'b0001;
    return one << id;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic all_outputs_zero(input string tag);
    chk({tag, "_req_rdy"}, req_rdy, 0);
    chk({tag, "_rsp_vld"}, rsp_vld, 0);
    chk({tag, "_eng_vld"}, eng_vld, 0);
    chk({tag, "_eng_res_rdy"}, eng_res_rdy, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_eng_fib_in"}, eng_fib_in, 0);
  endtask

  // One full transaction: grant, engine issue (with optional stall), result, response (with optional stall).
  task automatic txn(input int id, input logic [7:0] n, input logic [31:0] res, input bit set_vld,
                     input int eng_stall, input int rsp_stall, input bit last);
    if (set_vld) begin
      req_vld[id]       = 1'b1;
      req_n[id*8 +: 8]  = n;
    end
    #1;
    chk($sformatf("grant_r%0d_n%0d", id, n), req_rdy, oh(id));
    tick();
    if (set_vld) req_vld[id] = 1'b0;
    chk("issue_eng_vld", eng_vld, 1);
    chk("issue_eng_fib_in", eng_fib_in, n);
    chk("issue_req_rdy", req_rdy, 0);
    for (int i = 0; i < eng_stall; i++) begin
      tick();
      chk("stall_eng_vld", eng_vld, 1);
      chk("stall_eng_fib_in", eng_fib_in, n);
    end
    eng_rdy = 1'b1;
    tick();
    eng_rdy = 1'b0;
    chk("wait_eng_res_rdy", eng_res_rdy, 1);
    chk("wait_eng_vld", eng_vld, 0);
    eng_res     = res;
    eng_res_vld = 1'b1;
    tick();
    eng_res_vld = 1'b0;
    eng_res     = 32'hFFFF_FFFF;
    chk($sformatf("rsp_vld_r%0d", id), rsp_vld, oh(id));
    chk($sformatf("rsp_data_n%0d", n), rsp_data, res);
`ifdef FIB_ARB_TIMEOUT_EN
    chk("rsp_err_normal", rsp_err, 0);
`endif
    for (int i = 0; i < rsp_stall; i++) begin
      rsp_rdy = ~oh(id);
      tick();
      chk("hold_rsp_vld", rsp_vld, oh(id));
      chk("hold_rsp_data", rsp_data, res);
      chk("hold_req_rdy", req_rdy, 0);
      chk("hold_eng_res_rdy", eng_res_rdy, 0);
    end
    rsp_rdy = oh(id);
    if (last) req_vld = 4'b0000;
    tick();
    rsp_rdy = 4'b0000;
    chk("done_rsp_vld", rsp_vld, 0);
    chk("done_rsp_data_held", rsp_data, res);
  endtask

  initial begin
    rst         = 1'b1;
    req_vld     = 4'b1111;
    req_n       = {8'd8, 8'd7, 8'd6, 8'd5};
    rsp_rdy     = 4'b0000;
    eng_rdy     = 1'b0;
    eng_res     = 32'd0;
    eng_res_vld = 1'b0;
    #2;
    all_outputs_zero("reset");
    tick();
    tick();
    all_outputs_zero("reset_edge");
    rst = 1'b0;

    // All four requesting continuously: grants 0,1,2,3,0
    txn(0, 8'd5, 32'd5,  1'b0, 0, 0, 1'b0);
    txn(1, 8'd6, 32'd8,  1'b0, 0, 0, 1'b0);
    txn(2, 8'd7, 32'd13, 1'b0, 0, 0, 1'b0);
    txn(3, 8'd8, 32'd21, 1'b0, 0, 0, 1'b0);
    txn(0, 8'd5, 32'd5,  1'b0, 0, 0, 1'b1);

    // Lone requester 0 with engine stall, then re-granted
    txn(0, 8'd10, 32'd55, 1'b1, 3, 0, 1'b0);
    txn(0, 8'd1,  32'd1,  1'b1, 0, 0, 1'b0);

    // Move rr_ptr to 3, then requesters 1 and 3 both valid: 3 wins, then 1
    txn(2, 8'd2, 32'd1, 1'b1, 0, 0, 1'b0);
    req_vld[1] = 1'b1; req_n[8 +: 8]  = 8'd4;
    req_vld[3] = 1'b1; req_n[24 +: 8] = 8'd3;
    txn(3, 8'd3, 32'd2, 1'b0, 0, 0, 1'b0);
    txn(1, 8'd4, 32'd3, 1'b0, 0, 0, 1'b1);

    // Response back-pressure for 5 cycles with another requester waiting
    req_vld[0] = 1'b1; req_n[0 +: 8] = 8'd12;
    txn(2, 8'd9,  32'd34,  1'b1, 0, 5, 1'b0);
    txn(0, 8'd12, 32'd144, 1'b0, 0, 0, 1'b1);

    // Reset during WAIT aborts the request
    req_vld[1] = 1'b1; req_n[8 +: 8] = 8'd7;
    #1;
    chk("abort_grant", req_rdy, oh(1));
    tick();
    req_vld[1] = 1'b0;
    eng_rdy = 1'b1;
    tick();
    eng_rdy = 1'b0;
    chk("abort_in_wait", eng_res_rdy, 1);
    rst = 1'b1;
    #1;
    all_outputs_zero("midrst");
    tick();
    all_outputs_zero("midrst_edge");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_rsp_after_abort", rsp_vld, 0);
    end
    txn(0, 8'd1, 32'd1, 1'b1, 0, 0, 1'b0);

`ifdef FIB_ARB_TIMEOUT_EN
    chk("idle_eng_res_rdy", eng_res_rdy, 1);
    req_vld[1] = 1'b1; req_n[8 +: 8] = 8'd20;
    #1;
    chk("to_grant", req_rdy, oh(1));
    tick();
    req_vld[1] = 1'b0;
    eng_rdy = 1'b1;
    tick();
    eng_rdy = 1'b0;
    for (int i = 0; i < 40 && rsp_vld !== oh(1); i++) tick();
    chk("to_rsp_vld", rsp_vld, oh(1));
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    rsp_rdy = oh(1);
    tick();
    rsp_rdy = 4'b0000;
    chk("to_done_rsp_vld", rsp_vld, 0);
    chk("to_idle_eng_res_rdy", eng_res_rdy, 1);
    eng_res     = 32'd77;
    eng_res_vld = 1'b1;
    tick();
    eng_res_vld = 1'b0;
    chk("late_res_no_rsp", rsp_vld, 0);
    chk("late_res_data_held", rsp_data, 0);
    txn(2, 8'd3, 32'd2, 1'b1, 0, 0, 1'b0);
`else
    chk("idle_eng_res_rdy", eng_res_rdy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
